// File: rtl/jbi_mout_mondo_ack_pkg.sv
// Shared JBI constants for the mondo ack/nack issue path: field widths,
// transaction codes, FSM encoding and small datapath helpers.
package jbi_mout_mondo_ack_pkg;

  localparam int unsigned JBI_AGNT_W = 5;
  localparam int unsigned JBI_CPU_W  = 10;
  localparam int unsigned JBI_TGT_W  = 15;
  localparam int unsigned JBI_CMD_W  = 5;
  localparam int unsigned JBI_GAP_W  = 4;
  localparam int unsigned JBI_CNT_W  = 8;

  localparam logic [JBI_CMD_W-1:0] JBI_TRANS_INT_ACK  = 5'b01011;
  localparam logic [JBI_CMD_W-1:0] JBI_TRANS_INT_NACK = 5'b01010;

  typedef enum logic [1:0] {
    MONDO_IDLE  = 2'b00,
    MONDO_REQ   = 2'b01,
    MONDO_ISSUE = 2'b10,
    MONDO_GAP   = 2'b11
  } mondo_state_e;

  function automatic logic [JBI_CMD_W-1:0] mondo_cmd(input logic ack);
    return ack ? JBI_TRANS_INT_ACK : JBI_TRANS_INT_NACK;
  endfunction

  function automatic logic [JBI_CNT_W-1:0] sat_inc(input logic [JBI_CNT_W-1:0] v);
    return (v == 8'hFF) ? v : (v + 8'h01);
  endfunction

endpackage

// File: rtl/jbi_mout_mondo_ack_gap_cnt.sv
// Idle-gap down counter: loaded when a transaction is granted, decremented
// while in GAP, zero flag tells the FSM when the gap has elapsed.
module jbi_mout_gap_cnt
  import jbi_mout_mondo_ack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 load,
  input  logic                 dec,
  input  logic [JBI_GAP_W-1:0] load_val,
  output logic                 zero
);

  logic [JBI_GAP_W-1:0] cnt_r;

  // Counter register; a decrement at zero is ignored so it can never wrap
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/jbi_mout_mondo_ack.sv
// Issues INT_ACK / INT_NACK JBus transactions for entries at the head of the
// mondo ack queue, one at a time, with a programmable idle gap after each.
module jbi_mout_mondo_ack
  import jbi_mout_mondo_ack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  ncio_mondo_req,
  input  logic                  ncio_mondo_ack,
  input  logic [JBI_AGNT_W-1:0] ncio_mondo_agnt_id,
  input  logic [JBI_CPU_W-1:0]  ncio_mondo_cpu_id,
  output logic                  mout_mondo_pop,
  input  logic [JBI_GAP_W-1:0]  csr_mondo_gap,
  output logic                  mondo_arb_req,
  input  logic                  mondo_arb_gnt,
  output logic                  mondo_jbus_vld,
  output logic [JBI_CMD_W-1:0]  mondo_jbus_cmd,
  output logic [JBI_TGT_W-1:0]  mondo_jbus_tgt,
  output logic [JBI_CNT_W-1:0]  mondo_nack_cnt
);

  mondo_state_e          state_r;
  mondo_state_e          state_nxt_s;
  logic                  capture_s;
  logic                  gap_load_s;
  logic                  gap_dec_s;
  logic                  gap_zero_s;
  logic                  issue_nxt_s;
  logic                  ack_hold_r;
  logic [JBI_AGNT_W-1:0] agnt_hold_r;
  logic [JBI_CPU_W-1:0]  cpu_hold_r;

  jbi_mout_gap_cnt u_gap_cnt (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (gap_load_s),
    .dec      (gap_dec_s),
    .load_val (csr_mondo_gap),
    .zero     (gap_zero_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r <= MONDO_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode; the gap is loaded on the grant so it is
  // sampled exactly as ISSUE is entered
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    gap_load_s  = 1'b0;
    gap_dec_s   = 1'b0;
    case (state_r)
      MONDO_IDLE: begin
        if (ncio_mondo_req) begin
          state_nxt_s = MONDO_REQ;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = MONDO_IDLE;
        end
      end
      MONDO_REQ: begin
        if (mondo_arb_gnt) begin
          state_nxt_s = MONDO_ISSUE;
          gap_load_s  = 1'b1;
        end else begin
          state_nxt_s = MONDO_REQ;
        end
      end
      MONDO_ISSUE: begin
        state_nxt_s = MONDO_GAP;
      end
      MONDO_GAP: begin
        if (gap_zero_s) begin
          state_nxt_s = MONDO_IDLE;
        end else begin
          state_nxt_s = MONDO_GAP;
          gap_dec_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = MONDO_IDLE;
      end
    endcase
  end

  assign issue_nxt_s = (state_nxt_s == MONDO_ISSUE);

  // Holding registers: only written by the IDLE capture
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ack_hold_r  <= 1'b0;
      agnt_hold_r <= 5'd0;
      cpu_hold_r  <= 10'd0;
    end else if (capture_s) begin
      ack_hold_r  <= ncio_mondo_ack;
      agnt_hold_r <= ncio_mondo_agnt_id;
      cpu_hold_r  <= ncio_mondo_cpu_id;
    end else begin
      ack_hold_r  <= ack_hold_r;
      agnt_hold_r <= agnt_hold_r;
      cpu_hold_r  <= cpu_hold_r;
    end
  end

  // Outputs are registered from the next state so they coincide with it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mondo_arb_req  <= 1'b0;
      mondo_jbus_vld <= 1'b0;
      mout_mondo_pop <= 1'b0;
      mondo_jbus_cmd <= 5'd0;
      mondo_jbus_tgt <= 15'd0;
    end else begin
      mondo_arb_req  <= (state_nxt_s == MONDO_REQ);
      mondo_jbus_vld <= issue_nxt_s;
      mout_mondo_pop <= issue_nxt_s;
      if (issue_nxt_s) begin
        mondo_jbus_cmd <= mondo_cmd(ack_hold_r);
        mondo_jbus_tgt <= {agnt_hold_r, cpu_hold_r};
      end else begin
        mondo_jbus_cmd <= 5'd0;
        mondo_jbus_tgt <= 15'd0;
      end
    end
  end

  // Saturating NACK counter, bumped as each NACK issue cycle completes
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mondo_nack_cnt <= 8'd0;
    end else if ((state_r == MONDO_ISSUE) && !ack_hold_r) begin
      mondo_nack_cnt <= sat_inc(mondo_nack_cnt);
    end else begin
      mondo_nack_cnt <= mondo_nack_cnt;
    end
  end

endmodule

// File: tb/tb_jbi_mout_mondo_ack.sv
// Self-checking bench for jbi_mout_mondo_ack: MAKQ queue model, arbiter
// responder and a transaction-level scoreboard.
module tb_jbi_mout_mondo_ack;

  typedef struct packed {
    logic       ack;
    logic [4:0] agnt;
    logic [9:0] cpu;
  } entry_t;

  typedef struct {
    logic        ack;
    logic [4:0]  agnt;
    logic [9:0]  cpu;
    logic [3:0]  gap;
    logic [4:0]  exp_cmd;
    logic [14:0] exp_tgt;
    int          exp_space;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        ncio_mondo_req = 1'b0;
  logic        ncio_mondo_ack = 1'b0;
  logic [4:0]  ncio_mondo_agnt_id = 5'd0;
  logic [9:0]  ncio_mondo_cpu_id = 10'd0;
  logic        mout_mondo_pop;
  logic [3:0]  csr_mondo_gap = 4'd0;
  logic        mondo_arb_req;
  logic        mondo_arb_gnt = 1'b0;
  logic        mondo_jbus_vld;
  logic [4:0]  mondo_jbus_cmd;
  logic [14:0] mondo_jbus_tgt;
  logic [7:0]  mondo_nack_cnt;

  jbi_mout_mondo_ack dut (
    .clk                (clk),
    .rst_l              (rst_l),
    .ncio_mondo_req     (ncio_mondo_req),
    .ncio_mondo_ack     (ncio_mondo_ack),
    .ncio_mondo_agnt_id (ncio_mondo_agnt_id),
    .ncio_mondo_cpu_id  (ncio_mondo_cpu_id),
    .mout_mondo_pop     (mout_mondo_pop),
    .csr_mondo_gap      (csr_mondo_gap),
    .mondo_arb_req      (mondo_arb_req),
    .mondo_arb_gnt      (mondo_arb_gnt),
    .mondo_jbus_vld     (mondo_jbus_vld),
    .mondo_jbus_cmd     (mondo_jbus_cmd),
    .mondo_jbus_tgt     (mondo_jbus_tgt),
    .mondo_nack_cnt     (mondo_nack_cnt)
  );

  always #5 clk = ~clk;

  entry_t makq[$];
  vec_t   vecs[5];
  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     n_nack = 0;
  int     n_pops = 0;
  int     req_age = 0;
  int     gnt_delay = 0;
  bit     stray_gnt = 0;
  bit     scramble = 0;
  bit     prev_grant = 0;
  logic        s_vld, s_pop, s_req;
  logic [4:0]  s_cmd;
  logic [14:0] s_tgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_nack_cnt();
    return (n_nack > 255) ? 255 : n_nack;
  endfunction

  // One cycle: sample at negedge, score, then drive the next inputs
  task automatic tick();
    entry_t e;
    @(negedge clk);
    cyc++;
    s_vld = mondo_jbus_vld;
    s_pop = mout_mondo_pop;
    s_req = mondo_arb_req;
    s_cmd = mondo_jbus_cmd;
    s_tgt = mondo_jbus_tgt;
    check("pop_eq_vld", s_pop, s_vld);
    check("vld_after_grant", s_vld, prev_grant);
    if (s_vld) begin
      check("pop_nonempty", makq.size() != 0, 1'b1);
      if (makq.size() != 0) begin
        e = makq.pop_front();
        check("sb_cmd", s_cmd, e.ack ? 5'b01011 : 5'b01010);
        check("sb_tgt", s_tgt, {e.agnt, e.cpu});
        if (!e.ack) n_nack++;
        n_pops++;
      end
    end else begin
      check("idle_cmd_tgt_zero", {s_cmd, s_tgt}, 20'h0);
    end
    if (s_req) req_age++; else req_age = 0;
    if (s_req) mondo_arb_gnt = (req_age > gnt_delay);
    else       mondo_arb_gnt = stray_gnt ? 1'($urandom_range(0, 1)) : 1'b0;
    prev_grant = s_req && mondo_arb_gnt;
    ncio_mondo_req = (makq.size() != 0);
    if (scramble && s_req) begin
      ncio_mondo_ack     = 1'($urandom_range(0, 1));
      ncio_mondo_agnt_id = 5'($urandom);
      ncio_mondo_cpu_id  = 10'($urandom);
    end else if (makq.size() != 0) begin
      ncio_mondo_ack     = makq[0].ack;
      ncio_mondo_agnt_id = makq[0].agnt;
      ncio_mondo_cpu_id  = makq[0].cpu;
    end else begin
      ncio_mondo_ack     = 1'b0;
      ncio_mondo_agnt_id = 5'd0;
      ncio_mondo_cpu_id  = 10'd0;
    end
  endtask

  task automatic wait_vld(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!s_vld && n < budget);
    check({name, "_vld_timeout"}, s_vld, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (makq.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, makq.size(), 0);
    repeat (20) tick();
    check({name, "_arb_req_idle"}, s_req, 1'b0);
    check({name, "_nack_cnt"}, mondo_nack_cnt, exp_nack_cnt());
  endtask

  // Asynchronous reset away from the clock edge; outputs must drop at once
  task automatic pulse_reset(input string name);
    #2;
    rst_l = 1'b0;
    #1;
    check({name, "_async_zero"},
          {mondo_jbus_vld, mout_mondo_pop, mondo_arb_req, mondo_jbus_cmd, mondo_jbus_tgt, mondo_nack_cnt},
          32'h0);
    n_nack = 0;
    prev_grant = 0;
    mondo_arb_gnt = 1'b0;
    repeat (2) tick();
    rst_l = 1'b1;
  endtask

  task automatic push(input logic ack, input logic [4:0] agnt, input logic [9:0] cpu);
    entry_t e;
    e.ack = ack;
    e.agnt = agnt;
    e.cpu = cpu;
    makq.push_back(e);
  endtask

  initial begin
    int t1;
    int pops0;
    entry_t e;

    vecs[0] = '{1'b1, 5'h03, 10'h011, 4'd0,  5'b01011, 15'h0C11, 4};
    vecs[1] = '{1'b0, 5'h1F, 10'h3FF, 4'd0,  5'b01010, 15'h7FFF, 4};
    vecs[2] = '{1'b1, 5'h00, 10'h000, 4'd3,  5'b01011, 15'h0000, 7};
    vecs[3] = '{1'b0, 5'h15, 10'h2AA, 4'd15, 5'b01010, 15'h56AA, 19};
    vecs[4] = '{1'b1, 5'h0A, 10'h155, 4'd7,  5'b01011, 15'h2955, 11};

    repeat (3) tick();
    rst_l = 1'b1;
    repeat (2) tick();
    check("reset_state",
          {mondo_jbus_vld, mout_mondo_pop, mondo_arb_req, mondo_jbus_cmd, mondo_jbus_tgt, mondo_nack_cnt},
          32'h0);

    // Single NACK with minimum gap: counter goes 0 -> 1
    csr_mondo_gap = 4'd0;
    push(1'b0, 5'h02, 10'h004);
    wait_vld("single_nack", 20);
    check("single_nack_cmd", s_cmd, 5'b01010);
    drain("single_nack");
    check("single_nack_cnt_one", mondo_nack_cnt, 8'd1);

    // Table: issued fields and issue-to-issue spacing for a pair of entries
    for (int i = 0; i < 5; i++) begin
      csr_mondo_gap = vecs[i].gap;
      push(vecs[i].ack, vecs[i].agnt, vecs[i].cpu);
      push(vecs[i].ack, vecs[i].agnt, vecs[i].cpu);
      wait_vld("vec", 40);
      check("vec_cmd", s_cmd, vecs[i].exp_cmd);
      check("vec_tgt", s_tgt, vecs[i].exp_tgt);
      t1 = cyc;
      wait_vld("vec_second", 60);
      check("vec_spacing", cyc - t1, vecs[i].exp_space);
      drain("vec");
    end

    // Delayed grant while the queue-side fields wobble: captured values win
    csr_mondo_gap = 4'd1;
    gnt_delay = 10;
    scramble = 1;
    push(1'b1, 5'h07, 10'h123);
    wait_vld("delayed_gnt", 40);
    check("delayed_gnt_tgt", s_tgt, {5'h07, 10'h123});
    scramble = 0;
    drain("delayed_gnt");

    // Randomized traffic with stray grants
    stray_gnt = 1;
    for (int b = 0; b < 4; b++) begin
      gnt_delay = b;
      csr_mondo_gap = 4'($urandom_range(0, 3));
      for (int k = 0; k < 10; k++) begin
        push(1'($urandom_range(0, 1)), 5'($urandom), 10'($urandom));
      end
      drain("random");
    end

    // 300 NACKs: counter must saturate and hold
    gnt_delay = 0;
    csr_mondo_gap = 4'd0;
    for (int k = 0; k < 300; k++) push(1'b0, 5'(k), 10'(k));
    drain("nack_sat");
    check("nack_sat_ff", mondo_nack_cnt, 8'hFF);
    stray_gnt = 0;

    // Reset while waiting in REQ: no pop, entry reissued after reset
    gnt_delay = 100;
    push(1'b1, 5'h11, 10'h0AB);
    begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!s_req && n < 20);
      check("rst_req_reached", s_req, 1'b1);
    end
    pulse_reset("rst_in_req");
    check("rst_req_cnt_cleared", mondo_nack_cnt, 8'd0);
    gnt_delay = 0;
    pops0 = n_pops;
    drain("rst_in_req");
    check("rst_req_single_pop", n_pops - pops0, 1);

    // Reset during ISSUE: the pop never completes, so the entry stays queued
    e.ack = 1'b0;
    e.agnt = 5'h01;
    e.cpu = 10'h002;
    makq.push_back(e);
    wait_vld("rst_issue", 20);
    pulse_reset("rst_in_issue");
    makq.push_front(e);
    pops0 = n_pops;
    drain("rst_in_issue");
    check("rst_issue_single_pop", n_pops - pops0, 1);
    check("rst_issue_nack_cnt", mondo_nack_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jbi_mout_mondo_ack.md
JBI_MOUT_MONDO_ACK -- requirements
Module: jbi_mout_mondo_ack

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_l  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port ncio_mondo_req  input  1  MAKQ non-empty; head entry valid.
REQ-004 SHALL have port ncio_mondo_ack  input  1  head entry type: 1=ack, 0=nack.
REQ-005 SHALL have port ncio_mondo_agnt_id  input  5  head entry JBus agent ID.
REQ-006 SHALL have port ncio_mondo_cpu_id  input  10  head entry target CPU ID.
REQ-007 SHALL have port mout_mondo_pop  output  1  one-cycle pop of MAKQ head.
REQ-008 SHALL have port csr_mondo_gap  input  4  extra idle cycles between transactions.
REQ-009 SHALL have port mondo_arb_req  output  1  request to JBus output arbiter.
REQ-010 SHALL have port mondo_arb_gnt  input  1  arbiter grant, one-cycle pulse.
REQ-011 SHALL have port mondo_jbus_vld  output  1  address-cycle valid strobe.
REQ-012 SHALL have port mondo_jbus_cmd  output  5  INT_ACK or INT_NACK transaction code.
REQ-013 SHALL have port mondo_jbus_tgt  output  15  {agnt_id, cpu_id} target field.
REQ-014 SHALL have port mondo_nack_cnt  output  8  saturating count of NACKs issued.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, ISSUE, GAP.
REQ-016 IDLE: when ncio_mondo_req=1, SHALL capture ack/agnt_id/cpu_id into holding registers and go to REQ next cycle.
REQ-017 REQ: SHALL drive mondo_arb_req=1; on mondo_arb_gnt=1 SHALL go to ISSUE next cycle.
REQ-018 ISSUE: SHALL assert mondo_jbus_vld=1 and mout_mondo_pop=1 for exactly one cycle, driving cmd/tgt from holding registers.
REQ-019 mondo_jbus_cmd SHALL be JBI_TRANS_INT_ACK (5'b01011) when held ack=1, else JBI_TRANS_INT_NACK (5'b01010).
REQ-020 GAP: SHALL stay 1+csr_mondo_gap cycles (minimum 1, maximum 16), then return to IDLE; csr_mondo_gap sampled on ISSUE entry.
REQ-021 Mandatory one-cycle GAP SHALL cover the MAKQ pointer update and RAM read latency so IDLE never samples a stale head.
REQ-022 mondo_arb_gnt outside REQ SHALL be ignored.
REQ-023 mondo_arb_req, mondo_jbus_vld, mout_mondo_pop SHALL be 0 in all states except as stated.
REQ-024 Holding registers SHALL NOT change outside IDLE capture; input changes in REQ/ISSUE have no effect.
REQ-025 mondo_nack_cnt SHALL increment on each ISSUE with cmd INT_NACK, saturating at 8'hFF (no wrap).
REQ-026 Throughput: back-to-back entries with gnt in first REQ cycle and csr_mondo_gap=0 SHALL issue every 4 cycles.
REQ-027 mondo_jbus_cmd/tgt SHALL be 0 when mondo_jbus_vld=0.

Reset
REQ-028 rst_l=0 SHALL asynchronously force IDLE, all outputs 0, holding registers 0, GAP counter 0, mondo_nack_cnt 0.
REQ-029 Reset mid-REQ/ISSUE SHALL abandon the transaction with no pop; entry reissued after reset per MAKQ state.

Structure
REQ-030 Widths (5, 10, 15), state encodings and JBI_TRANS_INT_ACK/INT_NACK codes SHALL live in the shared jbi.h constant set.
REQ-031 The GAP counter SHALL be a sub-module jbi_mout_gap_cnt (load, decrement, zero flag).
REQ-032 Flops SHALL use the codebase asynchronous-reset flop primitives; no latches.

Verification
REQ-033 Single ack: req=1, ack=1, agnt=5'h03, cpu=10'h011, gnt one cycle after arb_req -> vld with cmd=5'b01011, tgt=15'h0C11, one pop.
REQ-034 Single nack, gap=0 -> cmd=5'b01010; nack_cnt 0->1; IDLE after exactly 1 GAP cycle.
REQ-035 Three queued entries, gap=3, immediate grants -> 3 vld pulses spaced 7 cycles, 3 pops, no pop while req=0.
REQ-036 Grant delayed 10 cycles, input fields changed in REQ -> issued tgt equals values captured in IDLE.
REQ-037 300 nacks -> nack_cnt holds 8'hFF; stray gnt in IDLE/GAP -> no vld.
REQ-038 rst_l low during REQ and during ISSUE -> outputs 0 immediately, no extra pop, clean restart in IDLE.
